// File: rtl/timetag_framer.sv
// Frames each timer rollover as a 4-word time-tag packet on a valid/ready stream.
// One pending slot absorbs a rollover that arrives mid-packet; further ones are counted as drops.
module timetag_framer #(
  parameter int         PERIOD_W = 48,
  parameter int         WORD_W   = 16,
  parameter logic [3:0] TAG_HDR  = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                period_done,
  input  logic [PERIOD_W-1:0] period,
  output logic [WORD_W-1:0]   tag_data,
  output logic                tag_valid,
  output logic                tag_last,
  input  logic                tag_ready,
  output logic [15:0]         drop_total
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_W2   = 3'd2;
  localparam logic [2:0] S_W1   = 3'd3;
  localparam logic [2:0] S_W0   = 3'd4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]          state, state_nxt;
  logic [PERIOD_W-1:0] cur, pend;
  logic                pend_full;
  logic [7:0]          drop_cnt, drop_cnt_nxt, drop_base;
  logic [7:0]          hdr_cnt;
  logic                adv, cap, cur_free, move, to_cur, to_pend, drop, hdr_acc;
  logic [WORD_W-1:0]   data_nxt;
  logic                last_nxt;

  assign tag_valid = (state != S_IDLE);
  assign adv       = tag_valid & tag_ready;
  assign cap       = en & period_done;
  assign cur_free  = (state == S_IDLE) | ((state == S_W0) & adv);
  // Emptying the slots on W0 accept happens before a same-cycle capture is placed.
  assign move      = cur_free & pend_full;
  assign to_cur    = cap & cur_free & ~pend_full;
  assign to_pend   = cap & ~to_cur & (~pend_full | move);
  assign drop      = cap & ~to_cur & ~to_pend;
  assign hdr_acc   = (state == S_HDR) & adv;

  // Drops that land while a header is held stay counted for the following header.
  always_comb begin
    drop_base    = hdr_acc ? (drop_cnt - hdr_cnt) : drop_cnt;
    drop_cnt_nxt = drop ? sat_inc8(drop_base) : drop_base;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (move | to_cur) state_nxt = S_HDR;
      S_HDR:   if (adv) state_nxt = S_W2;
      S_W2:    if (adv) state_nxt = S_W1;
      S_W1:    if (adv) state_nxt = S_W0;
      S_W0:    if (adv) state_nxt = (move | to_cur) ? S_HDR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    data_nxt = '0;
    last_nxt = 1'b0;
    case (state_nxt)
      S_HDR: data_nxt = {TAG_HDR, {(WORD_W-12){1'b0}}, drop_cnt_nxt};
      S_W2:  data_nxt = cur[3*WORD_W-1 -: WORD_W];
      S_W1:  data_nxt = cur[2*WORD_W-1 -: WORD_W];
      S_W0: begin
        data_nxt = cur[WORD_W-1:0];
        last_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cur        <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      drop_cnt   <= '0;
      hdr_cnt    <= '0;
      drop_total <= '0;
      tag_data   <= '0;
      tag_last   <= 1'b0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_cnt_nxt;
      if (drop) drop_total <= sat_inc16(drop_total);
      if (move) cur <= pend;
      else if (to_cur) cur <= period;
      if (to_pend) begin
        pend      <= period;
        pend_full <= 1'b1;
      end else if (move) begin
        pend_full <= 1'b0;
      end
      // Output word is registered on each state change so it holds through backpressure.
      if (state_nxt != state) begin
        tag_data <= data_nxt;
        tag_last <= last_nxt;
        if (state_nxt == S_HDR) hdr_cnt <= drop_cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_timetag_framer.sv
// Self-checking bench for timetag_framer: table-driven packets, scoreboard monitor,
// and hand-timed sequences for backpressure, pending slot, drop counting, enable and reset.
module tb_timetag_framer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        period_done;
  logic [47:0] period;
  logic [15:0] tag_data;
  logic        tag_valid;
  logic        tag_last;
  logic        tag_ready;
  logic [15:0] drop_total;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } word_t;

  word_t sb[$];

  typedef struct {
    logic [47:0] period;
    logic [15:0] hdr, w2, w1, w0;
  } vec_t;

  vec_t vecs[3];

  timetag_framer dut (
    .clk(clk), .rst(rst), .en(en), .period_done(period_done), .period(period),
    .tag_data(tag_data), .tag_valid(tag_valid), .tag_last(tag_last),
    .tag_ready(tag_ready), .drop_total(drop_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input logic [15:0] h, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c);
    sb.push_back('{h, 1'b0});
    sb.push_back('{a, 1'b0});
    sb.push_back('{b, 1'b0});
    sb.push_back('{c, 1'b1});
  endtask

  // Called at posedge+1; holds period_done for exactly one clock, returns at posedge+1.
  task automatic pulse(input logic [47:0] p);
    period      = p;
    period_done = 1'b1;
    @(posedge clk);
    #1 period_done = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && tag_valid && tag_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {tag_last, tag_data}, 32'hDEAD);
      end else begin
        word_t w;
        w = sb.pop_front();
        chk("sb_data", tag_data, w.data);
        chk("sb_last", tag_last, w.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{48'hFFFF_FFFF_FFFF, 16'hF000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[1] = '{48'h0000_0000_0000, 16'hF000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{48'hDEAD_BEEF_CAFE, 16'hF000, 16'hDEAD, 16'hBEEF, 16'hCAFE};

    rst = 1'b0; en = 1'b1; period_done = 1'b0; period = '0; tag_ready = 1'b1;
    #1;
    chk("rst_valid", tag_valid, 0);
    chk("rst_data", tag_data, 0);
    chk("rst_last", tag_last, 0);
    chk("rst_drop_total", drop_total, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic packet, ready high: HDR next cycle, four back-to-back words, then idle.
    push_pkt(16'hF000, 16'h0123, 16'h4567, 16'h89AB);
    pulse(48'h0123_4567_89AB);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", tag_valid, 1);
      chk("t1_last", tag_last, (k == 3));
    end
    @(negedge clk);
    chk("t1_idle", tag_valid, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      push_pkt(vecs[i].hdr, vecs[i].w2, vecs[i].w1, vecs[i].w0);
      pulse(vecs[i].period);
      drain(10);
    end

    // Backpressure on the header.
    tag_ready = 1'b0;
    push_pkt(16'hF000, 16'h1111, 16'h2222, 16'h3333);
    pulse(48'h1111_2222_3333);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t2_hold_valid", tag_valid, 1);
      chk("t2_hold_data", tag_data, 16'hF000);
    end
    @(posedge clk);
    #1 tag_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t2_b2b_done", sb.size(), 0);
    chk("t2_idle", tag_valid, 0);
    @(posedge clk);
    #1;

    // Three rollovers under backpressure: one in cur, one pending, one dropped.
    tag_ready = 1'b0;
    push_pkt(16'hF000, 16'h0000, 16'h0000, 16'h0005);
    push_pkt(16'hF001, 16'h0000, 16'h0000, 16'h0006);
    pulse(48'd5);
    pulse(48'd6);
    pulse(48'd7);
    @(negedge clk);
    chk("t3_drop_total", drop_total, 1);
    @(posedge clk);
    #1 tag_ready = 1'b1;
    drain(20);
    chk("t3_idle", tag_valid, 0);
    chk("t3_drop_total_after", drop_total, 1);

    // Rollover exactly on the W0 accept cycle: next HDR with no idle gap.
    push_pkt(16'hF000, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    push_pkt(16'hF000, 16'h1234, 16'h5678, 16'h9ABC);
    pulse(48'hAAAA_BBBB_CCCC);
    repeat (3) @(posedge clk);
    #1;
    pulse(48'h1234_5678_9ABC);
    @(negedge clk);
    chk("t4_no_gap_valid", tag_valid, 1);
    chk("t4_no_gap_data", tag_data, 16'hF000);
    @(posedge clk);
    #1;
    drain(10);

    // Enable low: rollovers ignored.
    en = 1'b0;
    pulse(48'h0000_0000_0001);
    pulse(48'h0000_0000_0002);
    repeat (2) begin
      @(negedge clk);
      chk("t5_en_off_valid", tag_valid, 0);
    end
    chk("t5_en_off_drop", drop_total, 1);
    @(posedge clk);
    #1 en = 1'b1;

    // Reset asserted mid-W1 abandons the packet immediately.
    push_pkt(16'hF000, 16'h7777, 16'h8888, 16'h9999);
    pulse(48'h7777_8888_9999);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_in_w1", tag_data, 16'h8888);
    rst = 1'b0;
    #1;
    sb.delete();
    chk("t5_rst_valid", tag_valid, 0);
    chk("t5_rst_data", tag_data, 0);
    chk("t5_rst_last", tag_last, 0);
    chk("t5_rst_drop_total", drop_total, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    push_pkt(16'hF000, 16'h0BAD, 16'hF00D, 16'h0042);
    pulse(48'h0BAD_F00D_0042);
    @(negedge clk);
    chk("t5_fresh_hdr", tag_data, 16'hF000);
    @(posedge clk);
    #1;
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
